// File: rtl/idle_packet_pkg.sv
// Shared definitions for the idle_packet register block and its datapath.
// Contents:
//   - Default stream, idle-length and timeout widths.
//   - The inserter FSM state type.
//   - tuser encodings for idle and source beats.
//   - A helper that maps a programmed idle length of 0 to 1.
package idle_packet_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_LEN_WIDTH  = 16;
  localparam int unsigned DEF_TMO_WIDTH  = 16;
  localparam int unsigned STAT_WIDTH     = 32;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    PASS = 2'd1,
    IDLE = 2'd2
  } state_e;

  localparam logic TUSER_IDLE = 1'b1;
  localparam logic TUSER_DATA = 1'b0;

  // A programmed idle length of zero still produces a one-beat packet.
  function automatic logic [DEF_LEN_WIDTH-1:0] eff_idle_len(
    input logic [DEF_LEN_WIDTH-1:0] len
  );
    return (len == '0) ? DEF_LEN_WIDTH'(1) : len;
  endfunction

endpackage

// File: rtl/idle_stream_inserter_out_slice.sv
// axis_out_slice: single-entry registered AXI4-Stream output stage.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   load_i                    write data_i/last_i/user_i into the slot
//                             (only legal while accept_o=1)
//   data_i, last_i, user_i    payload to load
//   ready_i                   downstream ready
//   accept_o                  slot can take a beat this cycle (combinational)
//   valid_o, data_o,          registered stream outputs
//   last_o, user_o
module axis_out_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  user_i,
  input  logic                  ready_i,
  output logic                  accept_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  user_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  last_q,  last_d;
  logic                  user_q,  user_d;

  // The slot frees up in the same cycle the downstream takes the held beat.
  assign accept_o = ~valid_q | ready_i;

  // Next-state for the slot; payload only changes on a load so it stays
  // stable under backpressure.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
      user_d  = user_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign user_o  = user_q;

endmodule

// File: rtl/idle_stream_inserter.sv
// idle_stream_inserter: forwards an AXI4-Stream source to the TX path and,
// once the source has been silent for cfg_timeout cycles, injects complete
// idle packets (tuser=1) so the downstream path never starves. Traffic
// switches between source and idle packets only on packet boundaries.
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   cfg_enable                idle insertion enable
//   cfg_idle_len              beats per idle packet (0 treated as 1)
//   cfg_idle_word             tdata of idle beats
//   cfg_timeout               silent cycles before an idle packet starts
//   s_axis_*                  source stream (tdata/tvalid/tlast/tready)
//   m_axis_*                  output stream (tdata/tvalid/tlast/tuser/tready)
//   stat_idle_pkts            completed idle packets, wrapping
module idle_stream_inserter
  import idle_packet_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned TMO_WIDTH  = DEF_TMO_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_enable,
  input  logic [LEN_WIDTH-1:0]  cfg_idle_len,
  input  logic [DATA_WIDTH-1:0] cfg_idle_word,
  input  logic [TMO_WIDTH-1:0]  cfg_timeout,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [STAT_WIDTH-1:0] stat_idle_pkts
);

  state_e                state_q, state_d;
  logic [TMO_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [LEN_WIDTH-1:0]  len_q,   len_d;
  logic [LEN_WIDTH-1:0]  idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] word_q,  word_d;
  logic [STAT_WIDTH-1:0] stat_q,  stat_d;

  logic                  accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_user;
  logic                  src_ready;
  logic                  idle_final;

  // Zero-length maps to one beat; computed at full width to cover any LEN_WIDTH.
  function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

  assign idle_final = (idx_q == (len_q - LEN_WIDTH'(1)));

  // Next-state, counters and slot-load selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    stat_d    = stat_q;
    src_ready = 1'b0;
    load      = 1'b0;
    ld_data   = s_axis_tdata;
    ld_last   = s_axis_tlast;
    ld_user   = TUSER_DATA;

    case (state_q)
      WAIT: begin
        src_ready = accept;
        if (s_axis_tvalid) begin
          // Source data always beats a coincident timeout.
          cnt_d = '0;
          if (accept) begin
            load = 1'b1;
            if (!s_axis_tlast) state_d = PASS;
          end
        end else if (cfg_enable && (cnt_q >= cfg_timeout)) begin
          cnt_d   = '0;
          len_d   = norm_len(cfg_idle_len);
          word_d  = cfg_idle_word;
          idx_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_WIDTH'(1);
        end
      end

      PASS: begin
        // Mid-packet: the source may stall forever, no idle insertion here.
        src_ready = accept;
        if (s_axis_tvalid && accept) begin
          load = 1'b1;
          if (s_axis_tlast) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end

      IDLE: begin
        ld_data = word_q;
        ld_last = idle_final;
        ld_user = TUSER_IDLE;
        if (accept) begin
          load = 1'b1;
          if (idle_final) begin
            idx_d   = '0;
            stat_d  = stat_q + STAT_WIDTH'(1);
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            idx_d = idx_q + LEN_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      len_q   <= LEN_WIDTH'(1);
      idx_q   <= '0;
      word_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      stat_q  <= stat_d;
    end
  end

  assign s_axis_tready  = src_ready & ~ARESET;
  assign stat_idle_pkts = stat_q;

  axis_out_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_slice (
    .clk_i    (ACLK),
    .rst_i    (ARESET),
    .load_i   (load),
    .data_i   (ld_data),
    .last_i   (ld_last),
    .user_i   (ld_user),
    .ready_i  (m_axis_tready),
    .accept_o (accept),
    .valid_o  (m_axis_tvalid),
    .data_o   (m_axis_tdata),
    .last_o   (m_axis_tlast),
    .user_o   (m_axis_tuser)
  );

endmodule

// File: tb/tb_idle_stream_inserter.sv
// Self-checking bench for idle_stream_inserter.
module tb_idle_stream_inserter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_enable;
  logic [15:0] cfg_idle_len;
  logic [31:0] cfg_idle_word;
  logic [15:0] cfg_timeout;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic [31:0] stat_idle_pkts;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  idle_stream_inserter dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .cfg_enable     (cfg_enable),
    .cfg_idle_len   (cfg_idle_len),
    .cfg_idle_word  (cfg_idle_word),
    .cfg_timeout    (cfg_timeout),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .stat_idle_pkts (stat_idle_pkts)
  );

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        lin;
    logic        rdy;
    logic        exp_sready;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_l;
    logic        exp_u;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] d,
                         input logic l, input logic u);
    chk({name, ".valid"}, 32'(m_axis_tvalid), 32'(v));
    chk({name, ".data"},  m_axis_tdata, d);
    chk({name, ".last"},  32'(m_axis_tlast), 32'(l));
    chk({name, ".user"},  32'(m_axis_tuser), 32'(u));
  endtask

  logic [31:0] bp_d [6];
  logic        bp_l [6];
  logic        bp_u [6];

  initial begin
    int n;
    int src_idx;
    int ohs;
    logic hs_in, hs_out, pv, pr, pl, pu;
    logic [31:0] pd;

    cfg_enable    = 1'b0;
    cfg_idle_len  = 16'd3;
    cfg_idle_word = 32'hDEADBEEF;
    cfg_timeout   = 16'd10;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state.
    ARESET = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.sready", 32'(s_axis_tready), 32'h0);
    chk("reset.stat", stat_idle_pkts, 32'h0);
    ARESET = 1'b0;

    // Pass-through with a single stall cycle, enable off.
    vecs[0] = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = vecs[i].vin;
      s_axis_tdata  = vecs[i].din;
      s_axis_tlast  = vecs[i].lin;
      m_axis_tready = vecs[i].rdy;
      #1;
      chk($sformatf("pt%0d.sready", i), 32'(s_axis_tready), 32'(vecs[i].exp_sready));
      tick();
      chk($sformatf("pt%0d.valid", i), 32'(m_axis_tvalid), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("pt%0d.data", i), m_axis_tdata, vecs[i].exp_d);
        chk($sformatf("pt%0d.last", i), 32'(m_axis_tlast), 32'(vecs[i].exp_l));
        chk($sformatf("pt%0d.user", i), 32'(m_axis_tuser), 32'(vecs[i].exp_u));
      end
    end
    s_axis_tvalid = 1'b0;
    chk("pt.stat", stat_idle_pkts, 32'h0);

    // Idle insertion after timeout 10, then boundary protection.
    cfg_enable    = 1'b1;
    cfg_timeout   = 16'd10;
    cfg_idle_len  = 16'd3;
    cfg_idle_word = 32'hDEADBEEF;
    m_axis_tready = 1'b1;
    do_reset();
    n = 0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (m_axis_tvalid) begin
        n = c;
        break;
      end
    end
    chk("idle.latency", 32'(n), 32'd12);
    chk_out("idle.b0", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA1;
    s_axis_tlast  = 1'b0;
    #1;
    chk("idle.b0.sready", 32'(s_axis_tready), 32'h0);
    tick();
    chk_out("idle.b1", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("idle.b1.sready", 32'(s_axis_tready), 32'h0);
    tick();
    chk_out("idle.b2", 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    chk("idle.stat", stat_idle_pkts, 32'd1);
    chk("idle.after.sready", 32'(s_axis_tready), 32'h1);
    tick();
    chk_out("follow.a1", 1'b1, 32'hA1, 1'b0, 1'b0);
    s_axis_tdata = 32'hA2;
    s_axis_tlast = 1'b1;
    tick();
    chk_out("follow.a2", 1'b1, 32'hA2, 1'b1, 1'b0);

    // Data coinciding with a zero timeout wins.
    cfg_timeout  = 16'd0;
    s_axis_tdata = 32'hB1;
    s_axis_tlast = 1'b1;
    tick();
    chk_out("coinc.b1", 1'b1, 32'hB1, 1'b1, 1'b0);
    chk("coinc.stat", stat_idle_pkts, 32'd1);

    // Zero length gives one-beat idle packets; zero timeout repeats them.
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_idle_len  = 16'd0;
    cfg_idle_word = 32'h55;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("len0.gap%0d", k), 32'(m_axis_tvalid), 32'h0);
      tick();
      chk_out($sformatf("len0.beat%0d", k), 1'b1, 32'h55, 1'b1, 1'b1);
      chk($sformatf("len0.stat%0d", k), stat_idle_pkts, 32'(k + 2));
    end

    // Backpressure: ready toggles across a data packet and an idle packet.
    bp_d[0] = 32'h11; bp_l[0] = 1'b0; bp_u[0] = 1'b0;
    bp_d[1] = 32'h12; bp_l[1] = 1'b0; bp_u[1] = 1'b0;
    bp_d[2] = 32'h13; bp_l[2] = 1'b1; bp_u[2] = 1'b0;
    bp_d[3] = 32'h77; bp_l[3] = 1'b0; bp_u[3] = 1'b1;
    bp_d[4] = 32'h77; bp_l[4] = 1'b0; bp_u[4] = 1'b1;
    bp_d[5] = 32'h77; bp_l[5] = 1'b1; bp_u[5] = 1'b1;
    cfg_timeout   = 16'd2;
    cfg_idle_len  = 16'd3;
    cfg_idle_word = 32'h77;
    do_reset();
    src_idx = 0;
    ohs     = 0;
    for (int c = 0; c < 200 && ohs < 6; c++) begin
      m_axis_tready = c[0];
      s_axis_tvalid = (src_idx < 3);
      s_axis_tdata  = 32'h11 + 32'(src_idx);
      s_axis_tlast  = (src_idx == 2);
      #1;
      hs_in  = s_axis_tvalid && s_axis_tready;
      hs_out = m_axis_tvalid && m_axis_tready;
      pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
      pl = m_axis_tlast;  pu = m_axis_tuser;
      if (hs_out) begin
        chk($sformatf("bp%0d.data", ohs), pd, bp_d[ohs]);
        chk($sformatf("bp%0d.last", ohs), 32'(pl), 32'(bp_l[ohs]));
        chk($sformatf("bp%0d.user", ohs), 32'(pu), 32'(bp_u[ohs]));
        ohs++;
      end
      tick();
      if (hs_in) src_idx++;
      if (pv && !pr) begin
        chk("bp.stall", {m_axis_tvalid, m_axis_tdata[30:0]}, {1'b1, pd[30:0]});
        chk("bp.stall.tl", {30'h0, m_axis_tlast, m_axis_tuser}, {30'h0, pl, pu});
      end
    end
    chk("bp.count", 32'(ohs), 32'd6);
    chk("bp.stat", stat_idle_pkts, 32'd1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset during the second beat of an idle packet.
    cfg_timeout   = 16'd0;
    cfg_idle_len  = 16'd3;
    cfg_idle_word = 32'h99;
    do_reset();
    for (int c = 0; c < 7; c++) tick();
    chk_out("rst.pre", 1'b1, 32'h99, 1'b0, 1'b1);
    chk("rst.pre.stat", stat_idle_pkts, 32'd1);
    ARESET = 1'b1;
    #1;
    chk("rst.sready", 32'(s_axis_tready), 32'h0);
    tick();
    chk_out("rst.post", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst.post.stat", stat_idle_pkts, 32'h0);
    ARESET = 1'b0;
    #1;
    chk("rst.wait.sready", 32'(s_axis_tready), 32'h1);
    tick();
    chk("rst.wait.valid", 32'(m_axis_tvalid), 32'h0);
    tick();
    chk_out("rst.restart", 1'b1, 32'h99, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
